// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out transmitter.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

`ifdef PISO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Number of serial bits in one frame: data bits plus the optional parity bit.
    function automatic int frame_len(input int width, input bit parity);
        return parity ? (width + 1) : width;
    endfunction

    // Width of the bit counter; it only has to reach frame_len-1, with one spare code.
    function automatic int cnt_width(input int flen);
        return $clog2(flen + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one serial frame.
// The counter can be loaded to zero or incremented. It saturates at FRAME_LEN-1 and never wraps.
// tc marks the last bit position. pre_tc marks the position just before it, so the owner
// can drive a registered end-of-frame strobe.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int FRAME_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic inc,
    output logic tc,
    output logic pre_tc
);

    localparam int CNT_W = cnt_width(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(FRAME_LEN - 2);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [CNT_W-1:0] bit_cnt_r;
    logic [CNT_W-1:0] bit_cnt_nxt_s;

    // Next count: a load restarts the count, an increment steps it, and the count holds at the last position.
    always_comb begin
        bit_cnt_nxt_s = bit_cnt_r;
        if (load) begin
            bit_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (inc && (bit_cnt_r != LAST_CNT)) begin
            bit_cnt_nxt_s = bit_cnt_r + ONE_CNT;
        end else begin
            bit_cnt_nxt_s = bit_cnt_r;
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt_r <= {CNT_W{1'b0}};
        end else begin
            bit_cnt_r <= bit_cnt_nxt_s;
        end
    end

    assign tc     = (bit_cnt_r == LAST_CNT);
    assign pre_tc = (bit_cnt_r == PRE_CNT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter, LSB first, with a valid/ready word handshake.
// Each serial bit is qualified by shift_en, so a right-shift SIPO receiver rebuilds the word.
// Back-to-back frames run with no idle gap when a new word is offered in the last bit cycle.
// Optional feature macro: PISO_PARITY_EN sends an even-parity bit after the data bits.
// Legal WIDTH range is 2..32.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             shift_en,
    output logic             frame_done,
    output logic             busy
);

    localparam int FRAME_LEN = frame_len(WIDTH, PARITY_EN);

    piso_state_e          state_r;
    piso_state_e          state_nxt_s;
    logic [FRAME_LEN-1:0] shreg_r;
    logic [FRAME_LEN-1:0] shreg_nxt_s;

    logic tc_s;
    logic pre_tc_s;
    logic last_s;
    logic accept_s;
    logic cnt_load_s;
    logic cnt_inc_s;

    logic serial_out_r;
    logic shift_en_r;
    logic frame_done_r;
    logic busy_r;
    logic serial_out_nxt_s;
    logic shift_en_nxt_s;
    logic frame_done_nxt_s;

`ifdef PISO_PARITY_EN
    // Even parity over the data word: XOR of all data bits.
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    // Frame image loaded into the shifter. The parity bit sits above the MSB and leaves last.
    function automatic logic [FRAME_LEN-1:0] load_word(input logic [WIDTH-1:0] d);
        return {even_parity(d), d};
    endfunction
`else
    // Frame image loaded into the shifter: the data word alone.
    function automatic logic [FRAME_LEN-1:0] load_word(input logic [WIDTH-1:0] d);
        return d;
    endfunction
`endif

    piso_bit_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .load   (cnt_load_s),
        .inc    (cnt_inc_s),
        .tc     (tc_s),
        .pre_tc (pre_tc_s)
    );

    // The last bit cycle doubles as an accept slot, so frames can be chained without a gap.
    assign last_s     = (state_r == SHIFT) && tc_s;
    assign in_ready   = (state_r == IDLE) || last_s;
    assign accept_s   = in_valid && in_ready;
    assign cnt_load_s = accept_s;
    assign cnt_inc_s  = (state_r == SHIFT);

    // Next-state and shifter logic: load on accept, shift while sending, return to idle after an unchained last bit.
    always_comb begin
        state_nxt_s = state_r;
        shreg_nxt_s = shreg_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = SHIFT;
                    shreg_nxt_s = load_word(in_data);
                end else begin
                    state_nxt_s = IDLE;
                    shreg_nxt_s = shreg_r;
                end
            end
            SHIFT: begin
                if (accept_s) begin
                    state_nxt_s = SHIFT;
                    shreg_nxt_s = load_word(in_data);
                end else if (last_s) begin
                    state_nxt_s = IDLE;
                    shreg_nxt_s = {1'b0, shreg_r[FRAME_LEN-1:1]};
                end else begin
                    state_nxt_s = SHIFT;
                    shreg_nxt_s = {1'b0, shreg_r[FRAME_LEN-1:1]};
                end
            end
            default: begin
                state_nxt_s = IDLE;
                shreg_nxt_s = {FRAME_LEN{1'b0}};
            end
        endcase
    end

    // Output look-ahead: the values the outputs take in the next cycle, derived from the next state.
    always_comb begin
        shift_en_nxt_s   = (state_nxt_s == SHIFT);
        serial_out_nxt_s = shift_en_nxt_s ? shreg_nxt_s[0] : 1'b0;
        // The next cycle is the last bit only when the current bit is the one before it.
        // A new accept restarts at bit 0, which is never the last bit because WIDTH >= 2.
        frame_done_nxt_s = (state_r == SHIFT) && !tc_s && pre_tc_s;
    end

    // State, shifter and output registers with synchronous active-low clear; a clear mid-frame drops the word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            shreg_r      <= {FRAME_LEN{1'b0}};
            serial_out_r <= 1'b0;
            shift_en_r   <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            shreg_r      <= shreg_nxt_s;
            serial_out_r <= serial_out_nxt_s;
            shift_en_r   <= shift_en_nxt_s;
            frame_done_r <= frame_done_nxt_s;
            busy_r       <= shift_en_nxt_s;
        end
    end

    assign serial_out = serial_out_r;
    assign shift_en   = shift_en_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (WIDTH=8).
// Also builds with PISO_PARITY_EN defined; frames then carry a hand-supplied parity bit.
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FL  = 9;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = 8;
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             serial_out;
    logic             shift_en;
    logic             frame_done;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] sipo;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .serial_out (serial_out),
        .shift_en   (shift_en),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference 8-bit right-shift SIPO receiver fed from the serial link.
    always @(posedge clk) begin
        if (!reset) begin
            sipo <= 8'h00;
        end else if (shift_en) begin
            sipo <= {serial_out, sipo[7:1]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected serial sequence of one frame: data bits, then the parity bit when enabled.
    function automatic logic [31:0] fr(input logic [7:0] w, input logic p);
        fr = PAR ? {23'd0, p, w} : {24'd0, w};
    endfunction

    task automatic chk_bit(input string tag, input logic eb, input logic efd, input logic eir);
        check({tag, ".shift_en"},   {31'd0, shift_en},   32'd1);
        check({tag, ".serial_out"}, {31'd0, serial_out}, {31'd0, eb});
        check({tag, ".frame_done"}, {31'd0, frame_done}, {31'd0, efd});
        check({tag, ".in_ready"},   {31'd0, in_ready},   {31'd0, eir});
        check({tag, ".busy"},       {31'd0, busy},       32'd1);
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".idle_shift_en"},   {31'd0, shift_en},   32'd0);
        check({tag, ".idle_serial_out"}, {31'd0, serial_out}, 32'd0);
        check({tag, ".idle_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, ".idle_busy"},       {31'd0, busy},       32'd0);
        check({tag, ".idle_in_ready"},   {31'd0, in_ready},   32'd1);
    endtask

    // Send one word from idle, check every bit cycle, then check the return to idle.
    task automatic send_frame(input string tag, input logic [7:0] w, input logic p);
        logic [31:0] seq;
        seq = fr(w, p);
        in_data  = w;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        in_data  = ~w;
        for (int k = 0; k < FL; k++) begin
            chk_bit(tag, seq[k], (k == FL - 1), (k == FL - 1));
            tick;
        end
        chk_idle(tag);
    endtask

    initial begin
        logic [31:0] seq2;

        // Hold reset with a word offered: nothing may start.
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) tick;
        check("rst.shift_en",   {31'd0, shift_en},   32'd0);
        check("rst.serial_out", {31'd0, serial_out}, 32'd0);
        check("rst.frame_done", {31'd0, frame_done}, 32'd0);
        check("rst.busy",       {31'd0, busy},       32'd0);
        reset    = 1'b1;
        in_valid = 1'b0;
        tick;
        chk_idle("post_rst");

        // Single word: A5 goes out as 1,0,1,0,0,1,0,1 (parity 0).
        send_frame("a5", 8'hA5, 1'b0);

        // Loopback through the reference SIPO.
        send_frame("loop", 8'h3C, 1'b0);
`ifdef PISO_PARITY_EN
        check("loop.sipo", {24'd0, sipo}, 32'h0000_001E);
`else
        check("loop.sipo", {24'd0, sipo}, 32'h0000_003C);
`endif

        // Back-to-back: FF then 01 with in_valid held; in_data changes mid-frame.
        seq2 = fr(8'hFF, 1'b0) | (fr(8'h01, 1'b1) << FL);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        tick;
        in_data = 8'h01;
        for (int k = 0; k < 2 * FL; k++) begin
            chk_bit("b2b", seq2[k], (k == FL - 1) || (k == 2 * FL - 1), (k == FL - 1) || (k == 2 * FL - 1));
            if (k == 2 * FL - 1) begin
                in_valid = 1'b0;
            end
            tick;
        end
        chk_idle("b2b");

        // Reset after the third bit of 0F aborts the frame.
        in_data  = 8'h0F;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_bit("abort", 1'b1, 1'b0, 1'b0);
            if (k < 2) begin
                tick;
            end
        end
        reset = 1'b0;
        tick;
        check("abort.shift_en",   {31'd0, shift_en},   32'd0);
        check("abort.frame_done", {31'd0, frame_done}, 32'd0);
        check("abort.busy",       {31'd0, busy},       32'd0);
        check("abort.serial_out", {31'd0, serial_out}, 32'd0);
        tick;
        check("abort2.shift_en",   {31'd0, shift_en},   32'd0);
        check("abort2.frame_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b1;
        send_frame("f0", 8'hF0, 1'b0);

`ifdef PISO_PARITY_EN
        // Parity frames: 07 -> parity 1, 03 -> parity 0.
        send_frame("par07", 8'h07, 1'b1);
        send_frame("par03", 8'h03, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock, LSB first.
- Each transmitted bit is qualified by a shift strobe. A right-shift SIPO receiver fed with serial_out/shift_en reassembles the word unchanged in its parallel register.
- Sits at the transmit end of the team's serial link, paired with the existing 8-bit SIPO capture block.

Parameters:
- WIDTH, 8, data word width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; reset=0 sampled at posedge clears the block.
- in_data  input  WIDTH  word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  current serial bit.
- shift_en  output  1  serial_out is valid this cycle; connects to receiver shift enable.
- frame_done  output  1  one-cycle pulse coincident with the last bit of a frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on port reset.
- Reset values: state=IDLE, shreg=0, bit_cnt=0, serial_out=0, shift_en=0, frame_done=0, busy=0.
- Reset asserted mid-frame aborts the frame immediately with no further strobes. A partially sent word is dropped, not retransmitted.
- FSM states are IDLE and SHIFT.
- FRAME_LEN = WIDTH (or WIDTH+1 with the optional feature). last = (state==SHIFT) && (bit_cnt==FRAME_LEN-1).
- in_ready is combinational: in_ready = (state==IDLE) || last. It has no dependence on in_valid.
- Accept happens when in_valid && in_ready at a posedge. On accept:
  - shreg <= in_data
  - bit_cnt <= 0
  - state <= SHIFT
- Latency: the first bit (in_data[0]) appears on serial_out with shift_en=1 in the cycle after accept.
- SHIFT state, each cycle:
  - serial_out = shreg[0], shift_en=1, busy=1.
  - Next cycle: shreg >> 1 and bit_cnt+1.
  - Bits go out in order in_data[0] .. in_data[WIDTH-1].
- In the last cycle:
  - frame_done=1.
  - If in_valid, the new word is accepted and its bit 0 follows on the very next cycle. There is no gap, so back-to-back frames give continuous shift_en.
  - Otherwise state <= IDLE and shift_en=0 in the next cycle.
- In IDLE: shift_en=0, serial_out=0, busy=0. in_data is ignored unless in_valid.
- in_data is sampled only at accept. Later changes to in_data have no effect on the frame in progress.
- bit_cnt width is $clog2(FRAME_LEN+1). It never wraps past FRAME_LEN-1.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - FRAME_LEN = WIDTH+1.
  - An even-parity bit (XOR of all in_data bits, computed at accept) is sent after data bit WIDTH-1.
  - frame_done coincides with the parity bit.
- Undefined:
  - FRAME_LEN = WIDTH.
  - No parity logic is synthesized.

Decomposition:
- Shared package piso_pkg:
  - state enum type (IDLE, SHIFT)
  - function frame_len(width, parity)
  - function for the bit-counter width
- One natural sub-module: piso_bit_counter. It is a load/increment counter with a terminal-count output (last) parameterized by FRAME_LEN. The FSM and shift register stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> all outputs 0, in_ready=0 is not required but no accept occurs; release reset -> in_ready=1, busy=0.
- Single word: in_data=8'hA5 for one cycle with in_valid=1 -> next 8 cycles serial_out=1,0,1,0,0,1,0,1 with shift_en=1; frame_done only in the 8th cycle; then shift_en=0.
- Loopback: feed serial_out/shift_en into an 8-bit right-shift SIPO model, send 8'h3C -> model's parallel register = 8'h3C after the 8th strobe.
- Back-to-back: 8'hFF then 8'h01 with in_valid held -> 16 consecutive shift_en cycles, serial_out=1×8 then 1,0,0,0,0,0,0,0; in_ready=1 only in cycles 8 and 16; two frame_done pulses.
- Mid-frame reset: send 8'h0F, assert reset=0 after the 3rd bit -> shift_en=0 from the next edge, no frame_done; after release, 8'hF0 is sent cleanly as 0,0,0,0,1,1,1,1.
- PISO_PARITY_EN defined: send 8'h07 -> 9 bits 1,1,1,0,0,0,0,0,1; frame_done on the 9th; 8'h03 -> 9th bit 0.
